// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, loader FSM states and the column one-hot decoder.
package aes_pkg;
    localparam int Nb = 4;
    typedef enum logic [1:0] {IDLE, FILL, HOLD} st_inload_e;
    typedef logic [7:0] byte_t;
    function automatic logic [Nb-1:0] col_onehot(input logic [1:0] col);
        return {{(Nb-1){1'b0}}, 1'b1} << col;
    endfunction
endpackage

// File: rtl/mod_inload_ctrl.sv
// mod_inload_ctrl: back-pressured byte loader filling four AES column registers column-major.
// Optional INLOAD_KEY_EN adds ld_key/blk_key for 32-byte key blocks delivered as two held halves.
module mod_inload_ctrl
    import aes_pkg::*;
#(
    parameter int NCOL  = 4,
    parameter int NBYTE = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            clr,
    input  logic            i_valid,
    input  logic [7:0]      i_data,
    output logic            o_ready,
    output logic [NCOL-1:0] col_wr_en,
    output logic [1:0]      col_idx,
    output logic [7:0]      col_data,
    output logic            blk_valid,
    input  logic            blk_ack,
`ifdef INLOAD_KEY_EN
    output logic            blk_key,
    input  logic            ld_key,
`endif
    output logic [7:0]      blk_cnt
);
    localparam int BLK = NCOL * NBYTE;
`ifdef INLOAD_KEY_EN
    localparam int CW = 5;
`else
    localparam int CW = 4;
`endif

    st_inload_e      r_state, w_state_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic [NCOL-1:0] r_wr_en;
    logic [1:0]      r_idx;
    byte_t           r_data;
    logic            r_blk_valid;
    logic [7:0]      r_blk_cnt;
    logic            w_accept, w_ack, w_last, w_keep;

    assign o_ready  = (r_state != HOLD);
    assign w_accept = i_valid && o_ready && !clr;
    assign w_ack    = blk_ack && r_blk_valid && !clr;
    assign w_last   = w_accept && (r_cnt[3:0] == 4'(BLK - 1));

`ifdef INLOAD_KEY_EN
    logic r_key;
    // The first key half keeps its count so the second half resumes at byte 16
    assign w_keep  = r_key && !r_cnt[4];
    assign blk_key = r_key && r_blk_valid;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_key <= 1'b0;
        else if (clr)
            r_key <= 1'b0;
        else if (w_accept && r_cnt == '0)
            r_key <= ld_key;
        else if (w_ack && r_cnt == '0)
            r_key <= 1'b0;
    end
`else
    assign w_keep = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        if (clr) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
        end else if (w_last) begin
            w_state_nx = HOLD;
            w_cnt_nx   = w_keep ? r_cnt + 1'b1 : '0;
        end else if (w_accept) begin
            w_state_nx = FILL;
            w_cnt_nx   = r_cnt + 1'b1;
        end else if (w_ack) begin
            w_state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_wr_en     <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_blk_valid <= 1'b0;
            r_blk_cnt   <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_wr_en     <= w_accept ? col_onehot(r_cnt[3:2]) : '0;
            // valid rises one edge after HOLD entry, once the final write has landed
            r_blk_valid <= !clr && (r_state == HOLD) && !w_ack;
            r_blk_cnt   <= r_blk_cnt + {7'd0, w_ack};
            if (w_accept) begin
                r_idx  <= r_cnt[1:0];
                r_data <= i_data;
            end
        end
    end

    assign col_wr_en = r_wr_en;
    assign col_idx   = r_idx;
    assign col_data  = r_data;
    assign blk_valid = r_blk_valid;
    assign blk_cnt   = r_blk_cnt;
endmodule

// File: doc/mod_inload_ctrl.md
# mod_inload_ctrl

Byte-input load sequencer for the AES-256 core's column registers. It accepts a byte stream over a valid/ready handshake and steers each byte into one of four 4-byte column registers (one-hot write enable plus byte-lane index). Once a complete 16-byte state block has been written, it presents the block to the round datapath and holds it until the datapath acknowledges it. It sits between the external byte interface and the column-register bank, replacing free-running, `i`-sensitive loading with a clocked, back-pressured protocol.

## Interface
- `NCOL`, 4: column registers per block; fixed at 4 for AES.
- `NBYTE`, 4: bytes per column register.
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous abort; discards the partial or held block.
- `i_valid`  in  1  input byte valid.
- `i_data`  in  8  input byte.
- `o_ready`  out  1  controller can accept a byte this cycle.
- `col_wr_en`  out  NCOL  one-hot write strobe to the column registers.
- `col_idx`  out  2  byte lane within the strobed column.
- `col_data`  out  8  byte to write.
- `blk_valid`  out  1  full block is present in the column registers.
- `blk_ack`  in  1  datapath has consumed the block.
- `blk_key`  out  1  held block is key material (present only with `INLOAD_KEY_EN`).
- `ld_key`  in  1  request key load (present only with `INLOAD_KEY_EN`).
- `blk_cnt`  out  8  count of completed blocks; wraps from 255 to 0.

## Operation
- FSM states:
  - IDLE: `o_ready`=1; the first accepted byte moves to FILL.
  - FILL: `o_ready`=1; the last byte of the block moves to HOLD.
  - HOLD: `o_ready`=0; `blk_valid` asserts.
  - A completed `blk_ack` handshake moves HOLD to IDLE.
- A byte is accepted at a rising edge where `i_valid`=1 and `o_ready`=1.
- Accepted byte k (0..15) is written to column k/4, lane k%4, so the block is loaded column-major in AES state order.
- `byte_cnt` is 4 bits (5 bits with key mode). It increments per accepted byte and clears on entry to HOLD.
- `o_ready` is decoded from the registered state, so no byte is accepted once the block is complete.
- A `blk_ack` that arrives while `blk_valid`=0 is ignored.
- `clr` has priority over every other input. It forces IDLE, clears `byte_cnt`, drops `blk_valid` and suppresses any pending `col_wr_en`. `blk_cnt` is unchanged.
- Reset, including mid-block, leaves every output at 0 except `o_ready`. The partial block is lost.

## Timing
- Reset values: state IDLE, `o_ready`=1, all other outputs 0 (`col_wr_en`, `col_idx`, `col_data`, `blk_valid`, `blk_key`, `blk_cnt`).
- Write latency is 1 cycle. A byte accepted at edge N produces a `col_wr_en`/`col_idx`/`col_data` pulse during cycle N→N+1.
- The `col_wr_en` pulse lasts exactly one cycle and is all-zero when no byte is accepted.
- When the last byte is accepted at edge N, the state is HOLD from edge N, the final write occurs during N→N+1, and `blk_valid`=1 from edge N+1. The column registers are therefore complete before `blk_valid` rises.
- `blk_valid` stays high until an edge where `blk_ack`=1. After that edge, `blk_valid`=0 and `o_ready`=1, and `blk_cnt` increments at the same edge.
- Back-to-back blocks have a minimum gap of 2 cycles between the last byte of one block and the first byte of the next, assuming `blk_ack` is tied high.
- When `clr` and `blk_ack` occur in the same cycle, `clr` wins and `blk_cnt` does not increment.

## Configuration
- Macro: `INLOAD_KEY_EN`.
- When defined:
  - Ports `ld_key` and `blk_key` exist.
  - `ld_key` is sampled at the acceptance of byte 0. If it is 1, the block is 32 bytes long, delivered as two 16-byte halves.
  - Each half runs its own HOLD/ack cycle, with `blk_key`=1 on both halves.
  - For the second half, FILL resumes from IDLE without resampling `ld_key`.
- When undefined: both ports are absent, every block is 16 bytes, and `byte_cnt` is 4 bits.

## Structure
- Shared package `aes_pkg`: `Nb`=4, the `st_inload_e` enum (IDLE, FILL, HOLD) and the `byte_t` typedef for 8-bit bytes.
- No sub-module. The one-hot decoder is an inline function in `aes_pkg`.

## Test plan
- Reset mid-FILL after 7 bytes: `o_ready`=1, `blk_valid`=0, `col_wr_en`=0; the next 16 bytes form a clean block.
- Bytes 0x00..0x0F with `i_valid` held high: `col_wr_en` sequence is 0001×4, 0010×4, 0100×4, 1000×4, with `col_idx` cycling 0..3. `blk_valid` rises 1 cycle after the final write; `o_ready`=0 in HOLD.
- Hold `blk_ack`=0 for 10 cycles and keep driving `i_valid`: no writes occur and `blk_valid` stays high. Raise `blk_ack`: `blk_cnt`=1 and `o_ready`=1 next cycle.
- Random `i_valid` gaps (about 50% duty) over 3 blocks: byte-to-lane mapping is preserved and `blk_cnt`=3.
- `clr` asserted together with `blk_ack` in HOLD: state is IDLE, `blk_cnt` unchanged, `blk_valid`=0.
- Key mode (`INLOAD_KEY_EN`), `ld_key`=1, 32 bytes: two HOLD phases, `blk_key`=1 on both, `blk_cnt`=2.
